johnson_counter_gen: RTL and testbench
======================================

# johnson_counter_gen

Parametrised shift-register counter generalising the fixed 4-bit Johnson counter. It is WIDTH bits wide and selectable at run time between Johnson (twisted-ring, 2·WIDTH states) and ring (one-hot, WIDTH states) sequences. It supports both shift directions, parallel load, illegal-state detection with self-correction, a decoded phase index and a wrap pulse. It is used as a phase/sequence generator for multi-phase enables and timing strobes.

## Interface
- WIDTH, 4, register width; legal range WIDTH ≥ 2
- PW (localparam), $clog2(2*WIDTH), width of phase output
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  advance one step per clock when high
- dir  in  1  0 = forward (shift toward MSB), 1 = backward (shift toward LSB)
- mode  in  1  0 = Johnson, 1 = ring
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value to load
- count  out  WIDTH  registered counter state
- phase  out  PW  position of count within the current sequence
- wrap  out  1  registered one-cycle pulse, home state reached by a step
- err  out  1  sticky flag, illegal state detected

## Operation
- HOME = {WIDTH-1 zeros, 1}, i.e. 0…01. It is legal in both modes.
- Legal Johnson states are 0…0 plus every state of the form of a contiguous run of ones anchored at the LSB or the MSB (2·WIDTH states). Legal ring states have exactly one bit set.
- Forward step: count ← {count[WIDTH-2:0], fb}, where fb = count[WIDTH-1] in ring mode and ~count[WIDTH-1] in Johnson mode.
- Backward step: count ← {fb, count[WIDTH-1:1]}, where fb = count[0] in ring mode and ~count[0] in Johnson mode.
- Next-state priority, evaluated every edge:
  1. rst: count ← HOME, err ← 0, wrap ← 0.
  2. load with load_val legal in current mode: count ← load_val, err ← 0.
  3. load with load_val illegal: count ← HOME, err ← 1.
  4. Current count illegal in current mode, regardless of en: count ← HOME, err ← 1.
  5. en: count ← step(count, dir, mode).
  6. Otherwise hold.
- wrap ← 1 only when case 5 produces count = HOME. It is 0 for load, correction, hold and reset.
- The phase decode is combinational from count and mode; it adds zero latency.
  - Johnson mode: phase = popcount(count) if count[WIDTH-1] = 0, else 2·WIDTH − popcount(count).
  - Ring mode: phase = index of the set bit.
  - When count is illegal, phase = 0.
- A mode change is allowed at any time. If the current state is illegal in the new mode, it is corrected per rule 4 on the next edge.
- dir may change on any cycle; the sequence reverses from the current state with no gap.

## Timing
- Reset values: count = HOME, phase = 1, wrap = 0, err = 0.
- count updates one cycle after an en or load sample; there is no pipeline.
- wrap is valid in the same cycle that count shows HOME after a step, with width exactly one clk.
- Period under continuous en: 2·WIDTH cycles in Johnson mode, WIDTH cycles in ring mode, in either direction.
- An illegal state persists at most one cycle before correction.
- rst asserted mid-sequence overrides load and en on that edge.
- err remains high until rst or a legal load.

## Test plan
- Johnson forward, WIDTH=4: rst, then en=1, dir=0, mode=0 → count 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; phase 1…7, 0, 1; wrap high only on the second 0001.
- Ring both directions, WIDTH=4: mode=1, dir=0 → 0001, 0010, 0100, 1000, 0001 (wrap on the return). Switching dir=1 at 0100 → 0010, 0001, with wrap on 0001.
- Johnson backward from HOME: dir=1 → 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001; phase 0, 7, 6, 5, 4, 3, 2, 1.
- Load: load_val=0111 in mode 0 → count 0111, phase 3, err 0. Then load_val=0101 → count 0001, err 1. Then load_val=1100 → err 0.
- Mode switch and reset: hold Johnson at 0011 with en=0 and set mode=1 → next edge count 0001, err 1, wrap 0. Then assert rst during a run → count 0001, err 0, wrap 0.
- WIDTH=8 instance: Johnson period measured at 16 enabled cycles and ring period at 8. Holding en low for random gaps does not change the sequence order.

Source files
------------

// File: rtl/johnson_counter_gen_if.sv
// Control/status bundle for johnson_counter_gen: step/load controls in, state and flags out.
interface johnson_counter_gen_if #(
  parameter int WIDTH = 4
);
  localparam int PW = $clog2(2*WIDTH);

  logic             en;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [PW-1:0]    phase;
  logic             wrap;
  logic             err;

  modport master (
    output en, dir, mode, load, load_val,
    input  count, phase, wrap, err
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output count, phase, wrap, err
  );
endinterface

// File: rtl/johnson_counter_gen.sv
// WIDTH-bit Johnson/ring sequence generator with bidirectional stepping, parallel load,
// illegal-state self-correction, combinational phase decode and a registered wrap pulse.
module johnson_counter_gen #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  johnson_counter_gen_if.slave bus
);
  localparam int PW = $clog2(2*WIDTH);
  localparam logic [WIDTH-1:0] HOME = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             err_q;
  logic [WIDTH-1:0] step_val;
  logic             count_legal;
  logic             load_legal;
  logic [PW-1:0]    phase_c;

  // Johnson-legal values are a run of ones anchored at the LSB (including all-zero)
  // or, equivalently for the inverted value, a run of ones anchored at the MSB.
  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
    logic [WIDTH-1:0] nv;
    nv = ~v;
    if (m)
      is_legal = (v != '0) && ((v & (v - HOME)) == '0);
    else
      is_legal = ((v & (v + HOME)) == '0) || ((nv & (nv + HOME)) == '0);
  endfunction

  always_comb begin
    count_legal = is_legal(count_q, bus.mode);
    load_legal  = is_legal(bus.load_val, bus.mode);
  end

  always_comb begin
    step_val = count_q;
    if (!bus.dir)
      step_val = {count_q[WIDTH-2:0], bus.mode ? count_q[WIDTH-1] : ~count_q[WIDTH-1]};
    else
      step_val = {bus.mode ? count_q[0] : ~count_q[0], count_q[WIDTH-1:1]};
  end

  always_comb begin
    phase_c = '0;
    if (count_legal) begin
      if (bus.mode) begin
        for (int i = 0; i < WIDTH; i++)
          if (count_q[i]) phase_c = PW'(i);
      end else if (count_q[WIDTH-1]) begin
        phase_c = PW'(2*WIDTH - $countones(count_q));
      end else begin
        phase_c = PW'($countones(count_q));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= HOME;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.load) begin
        if (load_legal) begin
          count_q <= bus.load_val;
          err_q   <= 1'b0;
        end else begin
          count_q <= HOME;
          err_q   <= 1'b1;
        end
      end else if (!count_legal) begin
        count_q <= HOME;
        err_q   <= 1'b1;
      end else if (bus.en) begin
        count_q <= step_val;
        wrap_q  <= (step_val == HOME);
      end
    end
  end

  assign bus.count = count_q;
  assign bus.phase = phase_c;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_johnson_counter_gen.sv
// Directed self-checking bench for johnson_counter_gen at WIDTH=4 and WIDTH=8.
module tb_johnson_counter_gen;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  johnson_counter_gen_if #(.WIDTH(4)) if4 ();
  johnson_counter_gen_if #(.WIDTH(8)) if8 ();

  johnson_counter_gen #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  johnson_counter_gen #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] ec, input logic [2:0] ep,
                      input logic ew, input logic ee);
    checks++;
    assert (if4.count === ec) else begin
      errors++; $error("FAIL %s count: got %b expected %b", tag, if4.count, ec);
    end
    checks++;
    assert (if4.phase === ep) else begin
      errors++; $error("FAIL %s phase: got %0d expected %0d", tag, if4.phase, ep);
    end
    checks++;
    assert (if4.wrap === ew) else begin
      errors++; $error("FAIL %s wrap: got %b expected %b", tag, if4.wrap, ew);
    end
    checks++;
    assert (if4.err === ee) else begin
      errors++; $error("FAIL %s err: got %b expected %b", tag, if4.err, ee);
    end
  endtask

  function automatic logic [7:0] jexp8(input int p);
    logic [7:0] ones;
    ones = 8'hFF;
    if (p <= 8) return 8'((1 << p) - 1);
    else        return ones << (p - 8);
  endfunction

  initial begin
    logic [3:0] jf  [8];
    logic [2:0] jfp [8];
    logic [3:0] jb  [8];
    logic [2:0] jbp [8];
    logic [3:0] rs  [6];
    logic [2:0] rsp [6];
    int  p, n;
    logic e, found;

    jf  = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
    jfp = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    jb  = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
    jbp = '{3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    rs  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    rsp = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2};

    rst = 1'b1;
    if4.en = 0; if4.dir = 0; if4.mode = 0; if4.load = 0; if4.load_val = '0;
    if8.en = 0; if8.dir = 0; if8.mode = 0; if8.load = 0; if8.load_val = '0;
    tick(); tick();
    chk4("reset", 4'b0001, 3'd1, 1'b0, 1'b0);

    // Johnson forward, full period
    rst = 1'b0; if4.en = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk4($sformatf("jfwd%0d", i), jf[i], jfp[i], i == 7, 1'b0);
    end

    // Johnson backward from HOME
    if4.dir = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk4($sformatf("jbwd%0d", i), jb[i], jbp[i], i == 7, 1'b0);
    end

    // Ring forward, then reverse at 0100
    if4.mode = 1; if4.dir = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk4($sformatf("rfwd%0d", i), rs[i], rsp[i], i == 3, 1'b0);
    end
    if4.dir = 1;
    tick(); chk4("rbwd0", 4'b0010, 3'd1, 1'b0, 1'b0);
    tick(); chk4("rbwd1", 4'b0001, 3'd0, 1'b1, 1'b0);

    if4.en = 0;
    tick(); chk4("hold", 4'b0001, 3'd0, 1'b0, 1'b0);

    // Parallel load: legal, illegal, legal again
    if4.mode = 0; if4.load = 1; if4.load_val = 4'b0111;
    tick(); chk4("load_ok", 4'b0111, 3'd3, 1'b0, 1'b0);
    if4.load_val = 4'b0101;
    tick(); chk4("load_bad", 4'b0001, 3'd1, 1'b0, 1'b1);
    if4.load_val = 4'b1100;
    tick(); chk4("load_clr", 4'b1100, 3'd6, 1'b0, 1'b0);
    if4.load_val = 4'b0011;
    tick(); chk4("load_0011", 4'b0011, 3'd2, 1'b0, 1'b0);

    // Mode switch makes 0011 illegal: phase reads 0 now, corrected on next edge
    if4.load = 0; if4.mode = 1;
    #1;
    checks++;
    assert (if4.phase === 3'd0) else begin
      errors++; $error("FAIL illegal_phase: got %0d expected 0", if4.phase);
    end
    tick(); chk4("mode_fix", 4'b0001, 3'd0, 1'b0, 1'b1);
    tick(); chk4("err_sticky", 4'b0001, 3'd0, 1'b0, 1'b1);

    // Reset mid-run overrides load and en
    if4.mode = 0; if4.dir = 0; if4.en = 1;
    tick(); chk4("run0", 4'b0011, 3'd2, 1'b0, 1'b1);
    tick(); chk4("run1", 4'b0111, 3'd3, 1'b0, 1'b1);
    rst = 1; if4.load = 1; if4.load_val = 4'b1111;
    tick(); chk4("rst_mid", 4'b0001, 3'd1, 1'b0, 1'b0);
    rst = 0; if4.load = 0;
    tick(); chk4("post_rst", 4'b0011, 3'd2, 1'b0, 1'b0);

    // Loading HOME is not a step: no wrap
    if4.load = 1; if4.load_val = 4'b0001;
    tick(); chk4("load_home", 4'b0001, 3'd1, 1'b0, 1'b0);
    if4.load = 0; if4.en = 0;

    // WIDTH=8 Johnson: period 16 enabled steps with random idle gaps
    rst = 1; tick(); rst = 0;
    checks++;
    assert (if8.count === 8'h01 && if8.phase === 4'd1) else begin
      errors++; $error("FAIL w8_reset: got %b/%0d expected 00000001/1", if8.count, if8.phase);
    end
    p = 1; n = 0; found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      e = 1'($urandom_range(0, 1));
      if8.en = e;
      tick();
      if (e) begin n++; p = (p + 1) % 16; end
      checks++;
      assert (if8.count === jexp8(p) && if8.phase === 4'(p) && if8.wrap === (e && p == 1)) else begin
        errors++;
        $error("FAIL w8_john step %0d: got %b/%0d/%b expected %b/%0d/%b",
               k, if8.count, if8.phase, if8.wrap, jexp8(p), p, e && p == 1);
      end
      if (e && if8.count === 8'h01) found = 1;
    end
    checks++;
    assert (found && n == 16) else begin
      errors++; $error("FAIL w8_john_period: got %0d (found=%b) expected 16", n, found);
    end

    // WIDTH=8 ring: period 8
    if8.en = 0; if8.mode = 1;
    p = 0; n = 0; found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      e = 1'($urandom_range(0, 1));
      if8.en = e;
      tick();
      if (e) begin n++; p = (p + 1) % 8; end
      checks++;
      assert (if8.count === (8'h01 << p) && if8.phase === 4'(p) && if8.wrap === (e && p == 0)) else begin
        errors++;
        $error("FAIL w8_ring step %0d: got %b/%0d/%b expected %b/%0d/%b",
               k, if8.count, if8.phase, if8.wrap, 8'h01 << p, p, e && p == 0);
      end
      if (e && if8.count === 8'h01) found = 1;
    end
    checks++;
    assert (found && n == 8) else begin
      errors++; $error("FAIL w8_ring_period: got %0d (found=%b) expected 8", n, found);
    end
    checks++;
    assert (if8.err === 1'b0) else begin
      errors++; $error("FAIL w8_err: got %b expected 0", if8.err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
